// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel for the fetch stage.
// The master side issues in-order fetch requests and accepts in-order responses.
interface if_fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps an in-order queue of fetch slots
// and produces the IF/ID register, with stall, redirect and stale-drop handling.
module if_fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [XLEN-1:0]            branch_target,
    if_fetch_stage_if.master           imem,
    output logic                       IF_ID_valid,
    output logic [XLEN-1:0]            IF_ID_PC,
    output logic [31:0]                IF_ID_instruction,
    output logic [$clog2(QDEPTH):0]    fetch_occupancy
);

    localparam int          PW  = $clog2(QDEPTH);
    localparam int          OW  = $clog2(QDEPTH) + 1;
    localparam int          DW  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [OW-1:0] QD = OW'(QDEPTH);

    logic [XLEN-1:0] pc;
    logic [OW-1:0]   head;
    logic [OW-1:0]   fill;
    logic [OW-1:0]   tail;
    logic [DW-1:0]   drop_cnt;

    logic [XLEN-1:0] slot_pc   [QDEPTH];
    logic [31:0]     slot_data [QDEPTH];

    logic [OW-1:0] occ;
    logic [OW-1:0] inflight;
    logic [OW-1:0] buffered;
    logic [PW-1:0] head_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] tail_idx;

    logic req_valid;
    logic req_fire;
    logic dropping;
    logic rsp_drop;
    logic rsp_take;
    logic rsp_hit;
    logic have_buf;
    logic bypass;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign occ      = tail - head;
    assign inflight = tail - fill;
    assign buffered = fill - head;
    assign head_idx = head[PW-1:0];
    assign fill_idx = fill[PW-1:0];
    assign tail_idx = tail[PW-1:0];

    assign req_valid = reset && !branch_taken && (occ < QD);
    assign req_fire  = req_valid && imem.imem_req_ready;

    // Stale responses are always the oldest outstanding ones, so drop first.
    assign dropping = (drop_cnt != '0);
    assign rsp_drop = imem.imem_rsp_valid && dropping;
    assign rsp_take = imem.imem_rsp_valid && !dropping && (inflight != '0);
    assign rsp_hit  = rsp_drop || rsp_take;

    assign have_buf = (buffered != '0);
    assign bypass   = !have_buf && rsp_take;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc;
    assign fetch_occupancy     = occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc                <= RESET_PC;
            head              <= '0;
            fill              <= '0;
            tail              <= '0;
            drop_cnt          <= '0;
            IF_ID_valid       <= 1'b0;
            IF_ID_PC          <= '0;
            IF_ID_instruction <= NOP;
        end else if (branch_taken) begin
            pc                <= branch_target & ~XLEN'(3);
            head              <= '0;
            fill              <= '0;
            tail              <= '0;
            drop_cnt          <= drop_cnt + DW'(inflight) - DW'(rsp_hit);
            IF_ID_valid       <= 1'b0;
            IF_ID_instruction <= NOP;
        end else begin
            if (req_fire) begin
                pc   <= pc + XLEN'(4);
                tail <= tail + OW'(1);
            end
            if (rsp_take) begin
                fill <= fill + OW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            if (!stall) begin
                unique case (1'b1)
                    have_buf: begin
                        IF_ID_valid       <= 1'b1;
                        IF_ID_PC          <= slot_pc[head_idx];
                        IF_ID_instruction <= slot_data[head_idx];
                        head              <= head + OW'(1);
                    end
                    bypass: begin
                        IF_ID_valid       <= 1'b1;
                        IF_ID_PC          <= slot_pc[head_idx];
                        IF_ID_instruction <= imem.imem_rsp_data;
                        head              <= head + OW'(1);
                    end
                    default: begin
                        IF_ID_valid       <= 1'b0;
                        IF_ID_instruction <= NOP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (!branch_taken) begin
            if (req_fire) begin
                slot_pc[tail_idx] <= pc;
            end
            if (rsp_take) begin
                slot_data[fill_idx] <= imem.imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order variable-latency memory plus an
// epoch/count reference of the expected instruction stream.
module tb_if_fetch_stage;

    localparam int          XLEN   = 64;
    localparam int          QDEPTH = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    logic            clk;
    logic            reset;
    logic            stall;
    logic            branch_taken;
    logic [63:0]     branch_target;
    logic            IF_ID_valid;
    logic [63:0]     IF_ID_PC;
    logic [31:0]     IF_ID_instruction;
    logic [1:0]      fetch_occupancy;

    if_fetch_stage_if #(.XLEN(XLEN)) imem ();

    if_fetch_stage #(
        .XLEN(XLEN),
        .RESET_PC(64'h0),
        .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem(imem),
        .IF_ID_valid(IF_ID_valid),
        .IF_ID_PC(IF_ID_PC),
        .IF_ID_instruction(IF_ID_instruction),
        .fetch_occupancy(fetch_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          epoch = 0;
    int          issued = 0;
    int          delivered = 0;
    int          consumed = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rsp_pct = 100;
    logic [63:0] req_pc = '0;
    logic [63:0] exp_pc = '0;
    mreq_t       mq[$];

    function automatic logic [31:0] insn(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A3C_0F01;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers, inputs applied, edge, then model update/check.
    task automatic cyc(input logic s, input logic b, input logic [63:0] t,
                       input logic rdy);
        logic        rv;
        logic        live;
        logic        fire;
        logic        pv;
        logic [63:0] ppc;
        logic [31:0] pin;
        mreq_t       e;
        rv   = 1'b0;
        live = 1'b0;
        imem.imem_rsp_data = $urandom;
        if (mq.size() != 0 && mq[0].due <= cycle &&
            $urandom_range(99) < rsp_pct) begin
            rv   = 1'b1;
            live = (mq[0].ep == epoch);
            imem.imem_rsp_data = insn(mq[0].addr);
            void'(mq.pop_front());
        end
        imem.imem_rsp_valid  = rv;
        imem.imem_req_ready  = rdy;
        stall                = s;
        branch_taken         = b;
        branch_target        = t;
        #1;
        chk("req_valid", imem.imem_req_valid,
            !b && ((issued - consumed) < QDEPTH));
        if (imem.imem_req_valid)
            chk("req_addr", imem.imem_req_addr, req_pc);
        fire = imem.imem_req_valid && rdy;
        if (fire) begin
            e.addr = imem.imem_req_addr;
            e.due  = cycle + $urandom_range(lat_max, lat_min);
            e.ep   = epoch;
            mq.push_back(e);
        end
        pv  = IF_ID_valid;
        ppc = IF_ID_PC;
        pin = IF_ID_instruction;
        @(posedge clk);
        #1;
        cycle++;
        if (b) begin
            epoch++;
            issued    = 0;
            delivered = 0;
            consumed  = 0;
            req_pc    = t & ~64'd3;
            exp_pc    = req_pc;
            chk("flush_valid", IF_ID_valid, 0);
            chk("flush_insn", IF_ID_instruction, NOP);
        end else begin
            if (fire) begin
                issued++;
                req_pc = req_pc + 64'd4;
            end
            if (rv && live) delivered++;
            if (s) begin
                chk("hold_valid", IF_ID_valid, pv);
                chk("hold_pc", IF_ID_PC, ppc);
                chk("hold_insn", IF_ID_instruction, pin);
            end else if (delivered > consumed) begin
                chk("ifid_valid", IF_ID_valid, 1);
                chk("ifid_pc", IF_ID_PC, exp_pc);
                chk("ifid_insn", IF_ID_instruction, insn(exp_pc));
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end else begin
                chk("bubble_valid", IF_ID_valid, 0);
                chk("bubble_insn", IF_ID_instruction, NOP);
                chk("bubble_pc", IF_ID_PC, ppc);
            end
        end
        chk("occupancy", fetch_occupancy, issued - consumed);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_req_ready = 1'b1;
        #1;
        chk("rst_valid", IF_ID_valid, 0);
        chk("rst_pc", IF_ID_PC, 0);
        chk("rst_insn", IF_ID_instruction, NOP);
        chk("rst_req_valid", imem.imem_req_valid, 0);
        chk("rst_occ", fetch_occupancy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", IF_ID_valid, 0);
        chk("rst_req_addr", imem.imem_req_addr, 0);
        mq.delete();
        epoch++;
        issued    = 0;
        delivered = 0;
        consumed  = 0;
        req_pc    = '0;
        exp_pc    = '0;
        reset     = 1'b1;
    endtask

    initial begin
        logic [63:0] hold_addr;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data = '0;
        imem.imem_req_ready = 1'b1;
        #1;
        do_reset();

        // straight-line fetch, 1-cycle memory
        repeat (6) cyc(1'b0, 1'b0, '0, 1'b1);
        chk("straight_valid", IF_ID_valid, 1);
        chk("straight_pc", IF_ID_PC, 64'h10);

        // stall with 0x10 held
        repeat (3) cyc(1'b1, 1'b0, '0, 1'b1);
        chk("stall_full", fetch_occupancy, 2);
        chk("stall_pc", IF_ID_PC, 64'h10);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("stall_next_pc", IF_ID_PC, 64'h14);
        chk("stall_next_valid", IF_ID_valid, 1);

        // redirect with two requests in flight
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 12 && mq.size() != 2; i++)
            cyc(1'b0, 1'b0, '0, 1'b1);
        chk("redir_inflight", fetch_occupancy >= 2'd1, 1);
        cyc(1'b0, 1'b1, 64'h103, 1'b1);
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 12 && !IF_ID_valid; i++)
            cyc(1'b0, 1'b0, '0, 1'b1);
        chk("redir_pc", IF_ID_PC, 64'h100);
        chk("redir_valid", IF_ID_valid, 1);

        // backpressure
        repeat (4) cyc(1'b0, 1'b0, '0, 1'b1);
        hold_addr = req_pc;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
            chk("bp_addr_stable", imem.imem_req_addr, hold_addr);
        end
        chk("bp_bubble", IF_ID_valid, 0);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);

        // stall + redirect while a response arrives
        cyc(1'b1, 1'b1, 64'h200, 1'b1);
        for (int i = 0; i < 12 && !IF_ID_valid; i++)
            cyc(1'b0, 1'b0, '0, 1'b1);
        chk("simul_pc", IF_ID_PC, 64'h200);

        // PC wrap at the top of the address space
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        repeat (8) cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_pc", IF_ID_PC, 64'h10);

        // mid-stream reset
        do_reset();
        for (int i = 0; i < 12 && !IF_ID_valid; i++)
            cyc(1'b0, 1'b0, '0, 1'b1);
        chk("restart_pc", IF_ID_PC, 64'h0);
        chk("restart_valid", IF_ID_valid, 1);

        // randomized traffic
        lat_min = 1;
        lat_max = 4;
        rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 20, $urandom_range(99) < 4,
                {$urandom, $urandom}, $urandom_range(99) < 75);
            if (i == 1500) begin
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
